// File: rtl/cache_req_arb.sv
// cache_req_arb: two-port request arbiter with in-order response steering.
// Define CACHE_REQ_ARB_RR_EN for round-robin ties; default is port 0 priority.
package cache_req_arb_pkg;
  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;
endpackage

module cache_req_arb
  import cache_req_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_val,
  output logic         req0_rdy,
  input  mem_req_4B_t  req0_msg,
  input  logic         req1_val,
  output logic         req1_rdy,
  input  mem_req_4B_t  req1_msg,
  output logic         resp0_val,
  input  logic         resp0_rdy,
  output mem_resp_4B_t resp0_msg,
  output logic         resp1_val,
  input  logic         resp1_rdy,
  output mem_resp_4B_t resp1_msg,
  output logic         cachereq_val,
  input  logic         cachereq_rdy,
  output mem_req_4B_t  cachereq_msg,
  input  logic         cacheresp_val,
  output logic         cacheresp_rdy,
  input  mem_resp_4B_t cacheresp_msg
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t           state;
  logic             lock_id;
  logic             win;
  logic             tie_pick;
  logic             fire;
  logic             pop;
  logic             full;
  logic             empty;
  logic             head;
  logic [DEPTH-1:0] tags;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

`ifdef CACHE_REQ_ARB_RR_EN
  logic rr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= 1'b0;
    end else if (fire) begin
      rr_ptr <= ~win;
    end
  end

  assign tie_pick = rr_ptr;
`else
  assign tie_pick = 1'b0;
`endif

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    win = tie_pick;
    if (state == LOCKED) begin
      win = lock_id;
    end else begin
      unique case (1'b1)
        (req0_val && !req1_val): win = 1'b0;
        (!req0_val && req1_val): win = 1'b1;
        default:                 win = tie_pick;
      endcase
    end
  end

  // Request side is gated by reset so nothing leaks out while held.
  assign cachereq_val = rst && (win ? req1_val : req0_val) && !full;
  assign cachereq_msg = win ? req1_msg : req0_msg;
  assign req0_rdy     = rst && !win && cachereq_rdy && !full;
  assign req1_rdy     = rst && win && cachereq_rdy && !full;
  assign fire         = cachereq_val && cachereq_rdy;

  assign head          = tags[rd_ptr];
  assign cacheresp_rdy = !empty && (head ? resp1_rdy : resp0_rdy);
  assign pop           = cacheresp_val && cacheresp_rdy;
  assign resp0_val     = cacheresp_val && !empty && !head;
  assign resp1_val     = cacheresp_val && !empty && head;
  assign resp0_msg     = cacheresp_msg;
  assign resp1_msg     = cacheresp_msg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      lock_id <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cachereq_val && !cachereq_rdy) begin
            state   <= LOCKED;
            lock_id <= win;
          end
        end
        LOCKED: begin
          if (fire) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tags   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fire) begin
        tags[wr_ptr] <= win;
        wr_ptr       <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (fire && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !fire) begin
        count <= count - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_cache_req_arb.sv
// tb_cache_req_arb: directed vectors for cache_req_arb.
// Expectations follow CACHE_REQ_ARB_RR_EN when defined.
module tb_cache_req_arb;
  import cache_req_arb_pkg::*;

  logic         clk;
  logic         rst;
  logic         req0_val;
  logic         req0_rdy;
  mem_req_4B_t  req0_msg;
  logic         req1_val;
  logic         req1_rdy;
  mem_req_4B_t  req1_msg;
  logic         resp0_val;
  logic         resp0_rdy;
  mem_resp_4B_t resp0_msg;
  logic         resp1_val;
  logic         resp1_rdy;
  mem_resp_4B_t resp1_msg;
  logic         cachereq_val;
  logic         cachereq_rdy;
  mem_req_4B_t  cachereq_msg;
  logic         cacheresp_val;
  logic         cacheresp_rdy;
  mem_resp_4B_t cacheresp_msg;

  int n_vec;
  int n_err;

  logic [3:0] exp_g;

  cache_req_arb #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_val     (req0_val),
    .req0_rdy     (req0_rdy),
    .req0_msg     (req0_msg),
    .req1_val     (req1_val),
    .req1_rdy     (req1_rdy),
    .req1_msg     (req1_msg),
    .resp0_val    (resp0_val),
    .resp0_rdy    (resp0_rdy),
    .resp0_msg    (resp0_msg),
    .resp1_val    (resp1_val),
    .resp1_rdy    (resp1_rdy),
    .resp1_msg    (resp1_msg),
    .cachereq_val (cachereq_val),
    .cachereq_rdy (cachereq_rdy),
    .cachereq_msg (cachereq_msg),
    .cacheresp_val(cacheresp_val),
    .cacheresp_rdy(cacheresp_rdy),
    .cacheresp_msg(cacheresp_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [79:0] got,
                     input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic mem_req_4B_t mk_req(input logic [31:0] a,
                                         input logic [7:0] op);
    mem_req_4B_t m;
    m.typ    = 3'd1;
    m.opaque = op;
    m.addr   = a;
    m.len    = 2'd0;
    m.data   = a ^ 32'h5a5a_0000;
    return m;
  endfunction

  function automatic mem_resp_4B_t mk_resp(input logic [31:0] d);
    mem_resp_4B_t m;
    m.typ    = 3'd0;
    m.opaque = d[7:0];
    m.test   = 2'd0;
    m.len    = 2'd0;
    m.data   = d;
    return m;
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
`ifdef CACHE_REQ_ARB_RR_EN
    exp_g = 4'b1010;
`else
    exp_g = 4'b0000;
`endif
    rst           = 1'b0;
    req0_val      = 1'b1;
    req1_val      = 1'b1;
    req0_msg      = mk_req(32'h0000_0100, 8'hA0);
    req1_msg      = mk_req(32'h0000_0200, 8'hB1);
    resp0_rdy     = 1'b1;
    resp1_rdy     = 1'b1;
    cachereq_rdy  = 1'b1;
    cacheresp_val = 1'b1;
    cacheresp_msg = mk_resp(32'h1234);

    // Held in reset with everything requesting.
    #2;
    chk("rst_creq_val", 80'(cachereq_val), 80'(0));
    chk("rst_req0_rdy", 80'(req0_rdy), 80'(0));
    chk("rst_req1_rdy", 80'(req1_rdy), 80'(0));
    chk("rst_resp0_val", 80'(resp0_val), 80'(0));
    chk("rst_resp1_val", 80'(resp1_val), 80'(0));
    chk("rst_cresp_rdy", 80'(cacheresp_rdy), 80'(0));
    tick();
    tick();
    chk("rst_hold_val", 80'(cachereq_val), 80'(0));
    chk("rst_count", 80'(dut.count), 80'(0));
    cacheresp_val = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;

    // Both requesting for four cycles, cache always ready.
    for (int i = 0; i < 4; i++) begin
      chk("alt_grant", 80'({req1_rdy, req0_rdy}),
          80'(exp_g[i] ? 2'b10 : 2'b01));
      chk("alt_msg", 80'(cachereq_msg),
          80'(exp_g[i] ? req1_msg : req0_msg));
      tick();
    end
    chk("full_count", 80'(dut.count), 80'(4));
    chk("full_creq_val", 80'(cachereq_val), 80'(0));

    // Drain in order; pop while full must not open the request path.
    cacheresp_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cacheresp_msg = mk_resp(32'hD000 + 32'(i));
      #1;
      if (i == 0) begin
        chk("full_pop_val", 80'(cachereq_val), 80'(0));
      end
      chk("drain_route", 80'({resp1_val, resp0_val}),
          80'(exp_g[i] ? 2'b10 : 2'b01));
      chk("drain_data",
          80'(exp_g[i] ? resp1_msg.data : resp0_msg.data),
          80'(32'hD000 + 32'(i)));
      tick();
      req0_val = 1'b0;
      req1_val = 1'b0;
    end
    cacheresp_val = 1'b0;
    #1;
    chk("drain_count", 80'(dut.count), 80'(0));

    // Lock: port 1 stalls on the cache, port 0 must not steal the grant.
    req1_msg     = mk_req(32'h0000_0040, 8'h41);
    req1_val     = 1'b1;
    cachereq_rdy = 1'b0;
    #1;
    chk("lock_val", 80'(cachereq_val), 80'(1));
    chk("lock_addr0", 80'(cachereq_msg.addr), 80'(32'h40));
    tick();
    req0_msg = mk_req(32'h0000_0000, 8'h00);
    req0_val = 1'b1;
    #1;
    chk("lock_addr1", 80'(cachereq_msg.addr), 80'(32'h40));
    chk("lock_req0_rdy", 80'(req0_rdy), 80'(0));
    tick();
    chk("lock_addr2", 80'(cachereq_msg.addr), 80'(32'h40));
    cachereq_rdy = 1'b1;
    #1;
    chk("lock_rel_grant", 80'({req1_rdy, req0_rdy}), 80'(2'b10));
    chk("lock_rel_msg", 80'(cachereq_msg), 80'(req1_msg));
    tick();
    req1_val = 1'b0;
    #1;
    chk("lock_next_grant", 80'({req1_rdy, req0_rdy}), 80'(2'b01));
    chk("lock_next_addr", 80'(cachereq_msg.addr), 80'(32'h0));
    tick();
    req0_val = 1'b0;
    chk("lock_count", 80'(dut.count), 80'(2));

    // Head is port 1 and it is not ready: response must wait.
    resp1_rdy     = 1'b0;
    cacheresp_val = 1'b1;
    cacheresp_msg = mk_resp(32'hBBBB);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_cresp_rdy", 80'(cacheresp_rdy), 80'(0));
      chk("bp_route", 80'({resp1_val, resp0_val}), 80'(2'b10));
      chk("bp_count", 80'(dut.count), 80'(2));
      tick();
    end
    resp1_rdy = 1'b1;
    #1;
    chk("bp_rel_rdy", 80'(cacheresp_rdy), 80'(1));
    chk("bp_rel_data", 80'(resp1_msg.data), 80'(32'hBBBB));
    tick();
    cacheresp_msg = mk_resp(32'hAAAA);
    #1;
    chk("bp_p0_route", 80'({resp1_val, resp0_val}), 80'(2'b01));
    chk("bp_p0_data", 80'(resp0_msg.data), 80'(32'hAAAA));
    tick();
    cacheresp_val = 1'b0;
    #1;
    chk("bp_count_end", 80'(dut.count), 80'(0));

    // Routing with a simultaneous push and pop at count 2.
    req0_msg = mk_req(32'h0000_0000, 8'h10);
    req0_val = 1'b1;
    tick();
    req0_val = 1'b0;
    req1_msg = mk_req(32'h0000_0010, 8'h11);
    req1_val = 1'b1;
    #1;
    chk("rt_first_rdy", 80'(req1_rdy), 80'(1));
    tick();
    req1_val = 1'b0;
    chk("rt_count", 80'(dut.count), 80'(2));
    req0_msg      = mk_req(32'h0000_0020, 8'h12);
    req0_val      = 1'b1;
    cacheresp_val = 1'b1;
    cacheresp_msg = mk_resp(32'hAAAA);
    #1;
    chk("pp_route", 80'({resp1_val, resp0_val}), 80'(2'b01));
    chk("pp_data", 80'(resp0_msg.data), 80'(32'hAAAA));
    chk("pp_req_rdy", 80'(req0_rdy), 80'(1));
    tick();
    req0_val = 1'b0;
    chk("pp_count", 80'(dut.count), 80'(2));
    cacheresp_msg = mk_resp(32'hBBBB);
    #1;
    chk("rt_p1_route", 80'({resp1_val, resp0_val}), 80'(2'b10));
    chk("rt_p1_data", 80'(resp1_msg.data), 80'(32'hBBBB));
    tick();
    cacheresp_msg = mk_resp(32'hCCCC);
    #1;
    chk("rt_p0_route", 80'({resp1_val, resp0_val}), 80'(2'b01));
    tick();
    chk("rt_count_end", 80'(dut.count), 80'(0));

    // Response with nothing outstanding.
    #1;
    chk("empty_rdy", 80'(cacheresp_rdy), 80'(0));
    chk("empty_route", 80'({resp1_val, resp0_val}), 80'(2'b00));
    tick();
    chk("empty_count", 80'(dut.count), 80'(0));
    cacheresp_val = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cache_req_arb.md
# cache_req_arb

Two-port arbiter that shares the single cache request/response port between requester 0 (instruction fetch) and requester 1 (data access). It selects one requester per transfer and forwards its `mem_req_4B_t` message unchanged. It records the winner in an in-order tag FIFO and steers each `mem_resp_4B_t` back to its originating requester. It sits between the processor's memory ports and the cache's `cachereq_*`/`cacheresp_*` interface, and it assumes the cache returns responses in request order.

## Interface
- `DEPTH`, default 4: maximum outstanding requests; power of two, ≥2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req0_val`, `req1_val`  in  1 each  requester request valid.
- `req0_rdy`, `req1_rdy`  out  1 each  request accepted.
- `req0_msg`, `req1_msg`  in  `mem_req_4B_t`  request messages.
- `resp0_val`, `resp1_val`  out  1 each  response valid to requester.
- `resp0_rdy`, `resp1_rdy`  in  1 each  requester response ready.
- `resp0_msg`, `resp1_msg`  out  `mem_resp_4B_t`  both driven from `cacheresp_msg`.
- `cachereq_val`  out  1, `cachereq_rdy`  in  1, `cachereq_msg`  out  `mem_req_4B_t`.
- `cacheresp_val`  in  1, `cacheresp_rdy`  out  1, `cacheresp_msg`  in  `mem_resp_4B_t`.

## Operation
- The FSM has two states.
  - IDLE: select a winner combinationally from the requesters with `val` asserted.
  - LOCKED: winner held in `lock_id`.
- IDLE→LOCKED when `cachereq_val && !cachereq_rdy`; the current winner is latched.
- LOCKED→IDLE on `cachereq_val && cachereq_rdy`. While LOCKED, `cachereq_msg` and the grant never change.
- `full` = count==DEPTH; `empty` = count==0; count width is clog2(DEPTH+1).
- `cachereq_val` = winner's `val` && !full; `cachereq_msg` = winner's msg; `reqN_rdy` = (winner==N) && `cachereq_rdy` && !full.
- Request fire = `cachereq_val && cachereq_rdy`. On fire:
  - push winner id into the tag FIFO;
  - update the round-robin pointer to the other port.
- The opaque field is passed through untouched.
- `respN_val` = `cacheresp_val` && !empty && head==N.
- `cacheresp_rdy` = !empty && `resp[head]_rdy`.
- Response fire pops the FIFO.
- `cacheresp_val` while empty is protocol error: `cacheresp_rdy` stays 0 and no requester sees `val`.
- Push and pop in the same cycle: count is unchanged, both pointers advance. Read and write pointers wrap modulo DEPTH.
- When full, a push is blocked even if a pop occurs the same cycle, so the full→push path is not combinational.
- Reset (asynchronous, any state):
  - count=0, pointers=0, FSM=IDLE, RR pointer=0 (port 0 favoured);
  - all outputs low except messages (which follow inputs).
- An in-flight cache transaction is discarded on reset.

## Timing
- Request path is combinational: zero-cycle latency from `reqN_val` to `cachereq_val`.
- Response steering is combinational from `cacheresp_val` and the FIFO head.
- At most one request and one response transfer per cycle.
- Tag pushed on request fire is visible at the FIFO head the next cycle. The earliest response routed is therefore one cycle after request fire.
- Sustained throughput is one request per cycle while count<DEPTH and the cache is ready.

## Configuration
- `CACHE_REQ_ARB_RR_EN` defined: round-robin. On a tie the port opposite the last granted port wins; the pointer updates on every request fire.
- Undefined: fixed priority, port 0 always wins ties. The RR pointer register is not built.
- The macro does not affect lock, FIFO or response behaviour.

## Test plan
- Reset sequencing: hold `rst`=0 with both vals high. Expect all `*_val`/`*_rdy` outputs = 0. Release, cache ready: port 0 granted first.
- Alternation: both vals held for 4 cycles, cache always ready.
  - With RR_EN: grants 0,1,0,1.
  - Without: 0,0,0,0.
  - FIFO count=4=full; next cycle `cachereq_val`=0.
- Lock: port 1 alone asserts addr 0x40 with cache not ready. Port 0 asserts next cycle. `cachereq_msg.addr` stays 0x40 until the cache raises `cachereq_rdy`, then port 0 is granted.
- Response routing: issue port 0 addr 0x00 and port 1 addr 0x10. The cache returns data 0xAAAA then 0xBBBB. `resp0` sees 0xAAAA and `resp1` sees 0xBBBB, in that order.
- Backpressure: head tag=1, `resp1_rdy`=0 with `cacheresp_val`=1 for 3 cycles. `cacheresp_rdy`=0 and count is held; the response is delivered when `resp1_rdy`=1.
- Simultaneous push/pop at count=2 leaves count=2. A response with an empty FIFO gets `cacheresp_rdy`=0.
